// File: rtl/adc1k_align_ctrl.sv
// ---------------------------------------------------------------------------
// adc1k_align_ctrl
//   IDELAY training controller for the 8-lane DDR capture path of the 1 GSPS
//   ADC. On start, it puts the ADC in test-pattern mode and sweeps every tap.
//   At each tap it loads the tap, waits for the delay line and IDDR to settle,
//   and then checks both IDDR outputs against the fixed pattern. When the
//   sweep is finished, each lane is loaded at the centre of its widest
//   passing window.
//
// Ports
//   dclk       ADC data clock (only clock)
//   reset_n    async active-low reset
//   start      one-cycle training request, ignored while busy
//   dout_1/2   IDDR Q1/Q2 per lane
//   test_mode  ADC test-pattern request, high for the whole run
//   tap_val    per-lane tap, lane l at [l*TAP_W +: TAP_W]
//   tap_ld     one-cycle VAR_LOAD strobe for all IDELAYs
//   busy       training in progress
//   done       set at end of run, cleared by the next accepted start
//   fail       any lane without a wide enough window (valid with done)
//   lane_ok    per-lane pass flags (valid with done)
// ---------------------------------------------------------------------------

// Per-lane window tracker: sticky error over CHECK, run/best tracking at EVAL,
// centre selection at CENTER.
module adc1k_align_lane #(
   parameter int   TAP_W   = 5,
   parameter int   MIN_WIN = 4,
   parameter logic P1      = 1'b1,
   parameter logic P2      = 1'b0
) (
   input  logic             dclk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             clr_err,
   input  logic             chk,
   input  logic             eval,
   input  logic             last,
   input  logic             center,
   input  logic [TAP_W-1:0] t,
   input  logic             d1,
   input  logic             d2,
   output logic [TAP_W-1:0] final_tap,
   output logic             ok
);
   logic             err;
   logic [TAP_W-1:0] cur_start, best_start, run_start, close_start;
   logic [TAP_W:0]   cur_len, best_len, run_len, close_len, ctr_sum;

   // A run is open whenever cur_len is non-zero.
   // close_len is zero whenever nothing closes on this tap.
   always_comb begin
      run_start   = (cur_len == '0) ? t : cur_start;
      run_len     = err ? '0 : cur_len + 1'b1;
      close_start = err ? cur_start : run_start;
      close_len   = err ? cur_len : (last ? run_len : '0);
      ctr_sum     = {1'b0, best_start} + (best_len >> 1);
   end

   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         err        <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
         final_tap  <= '0;
         ok         <= 1'b0;
      end else if (clr) begin
         err        <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
         final_tap  <= '0;
         ok         <= 1'b0;
      end else begin
         if (clr_err)
            err <= 1'b0;
         else if (chk && (d1 != P1 || d2 != P2))
            err <= 1'b1;
         if (eval) begin
            cur_start <= run_start;
            cur_len   <= last ? '0 : run_len;
            // Strict compare: of equal windows, the earliest is kept.
            if (close_len > best_len) begin
               best_start <= close_start;
               best_len   <= close_len;
            end
         end
         if (center) begin
            if (best_len >= (TAP_W+1)'(MIN_WIN)) begin
               final_tap <= ctr_sum[TAP_W-1:0];
               ok        <= 1'b1;
            end else begin
               final_tap <= TAP_W'(1 << (TAP_W-1));
               ok        <= 1'b0;
            end
         end
      end
   end
endmodule

module adc1k_align_ctrl #(
   parameter int               LANES     = 8,
   parameter int               TAP_W     = 5,
   parameter int               SETTLE    = 16,
   parameter int               CHECK_LEN = 64,
   parameter int               MIN_WIN   = 4,
   parameter logic [LANES-1:0] PAT_1     = 8'h55,
   parameter logic [LANES-1:0] PAT_2     = 8'hAA
) (
   input  logic                   dclk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [LANES-1:0]       dout_1,
   input  logic [LANES-1:0]       dout_2,
   output logic                   test_mode,
   output logic [LANES*TAP_W-1:0] tap_val,
   output logic                   tap_ld,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [LANES-1:0]       lane_ok
);
   localparam int CMAX  = (SETTLE > CHECK_LEN) ? SETTLE : CHECK_LEN;
   localparam int CNT_W = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_APPLY, S_FIN
   } state_t;

   state_t                        st, nxt;
   logic [CNT_W-1:0]              cnt;
   logic [TAP_W-1:0]              t;
   logic                          last;
   logic [LANES-1:0][TAP_W-1:0]   fin_tap;

   assign last = (t == '1);

   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) st <= S_IDLE;
      else          st <= nxt;
   end

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:   if (start) nxt = S_LOAD;
         S_LOAD:   nxt = S_SETTLE;
         S_SETTLE: if (cnt == CNT_W'(SETTLE - 1)) nxt = S_CHECK;
         S_CHECK:  if (cnt == CNT_W'(CHECK_LEN - 1)) nxt = S_EVAL;
         S_EVAL:   nxt = last ? S_CENTER : S_LOAD;
         S_CENTER: nxt = S_APPLY;
         S_APPLY:  nxt = S_FIN;
         S_FIN:    nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the current state, so each state's action
   // becomes visible in the following cycle.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         t         <= '0;
         tap_val   <= '0;
         tap_ld    <= 1'b0;
         busy      <= 1'b0;
         test_mode <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         tap_ld <= 1'b0;
         cnt    <= ((st == S_SETTLE || st == S_CHECK) && nxt == st) ? cnt + 1'b1 : '0;
         case (st)
            S_IDLE: if (start) begin
               t         <= '0;
               done      <= 1'b0;
               fail      <= 1'b0;
               busy      <= 1'b1;
               test_mode <= 1'b1;
            end
            S_LOAD: begin
               tap_val <= {LANES{t}};
               tap_ld  <= 1'b1;
            end
            S_EVAL: if (!last) t <= t + 1'b1;
            S_APPLY: begin
               tap_val <= fin_tap;
               tap_ld  <= 1'b1;
            end
            S_FIN: begin
               busy      <= 1'b0;
               test_mode <= 1'b0;
               done      <= 1'b1;
               fail      <= ~&lane_ok;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      adc1k_align_lane #(
         .TAP_W(TAP_W), .MIN_WIN(MIN_WIN), .P1(PAT_1[g]), .P2(PAT_2[g])
      ) u_lane (
         .dclk      (dclk),
         .reset_n   (reset_n),
         .clr       (st == S_IDLE && start),
         .clr_err   (st == S_SETTLE),
         .chk       (st == S_CHECK),
         .eval      (st == S_EVAL),
         .last      (last),
         .center    (st == S_CENTER),
         .t         (t),
         .d1        (dout_1[g]),
         .d2        (dout_2[g]),
         .final_tap (fin_tap[g]),
         .ok        (lane_ok[g])
      );
   end
endmodule

// File: tb/tb_adc1k_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc1k_align_ctrl
//   Emulates the IDELAY+ADC: each lane returns the test pattern when the tap
//   it last loaded is marked passing in pass_tbl, and a corrupted word when it
//   is not. The expected taps come from a window search over the tables.
// ---------------------------------------------------------------------------
module tb_adc1k_align_ctrl;
   localparam int         LANES = 8;
   localparam int         TAP_W = 5;
   localparam logic [7:0] PAT_1 = 8'h55;
   localparam logic [7:0] PAT_2 = 8'hAA;
   localparam int         RUN   = 2627;

   logic                   dclk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [LANES-1:0]       dout_1, dout_2;
   logic                   test_mode, tap_ld, busy, done, fail;
   logic [LANES*TAP_W-1:0] tap_val;
   logic [LANES-1:0]       lane_ok;

   int vectors = 0, errors = 0;

   logic [31:0]      pass_tbl [LANES];  // what the emulated lanes do
   logic [31:0]      exp_tbl  [LANES];  // what the DUT should effectively see
   logic [TAP_W-1:0] cur_tap  [LANES];
   logic [LANES-1:0] flip = '0;
   int               brk_mode = 3;

   // Results captured by do_run
   int                     r_lat, r_first_ld, r_last_ld;
   logic                   r_busy0, r_tm0, r_busy_d, r_tm_d, r_fail;
   logic [LANES*TAP_W-1:0] r_taps;
   logic [LANES-1:0]       r_ok;

   // Expectations
   logic [LANES*TAP_W-1:0] e_taps;
   logic [LANES-1:0]       e_ok;

   adc1k_align_ctrl dut (
      .dclk(dclk), .reset_n(reset_n), .start(start),
      .dout_1(dout_1), .dout_2(dout_2), .test_mode(test_mode),
      .tap_val(tap_val), .tap_ld(tap_ld), .busy(busy), .done(done),
      .fail(fail), .lane_ok(lane_ok)
   );

   always #5 dclk = ~dclk;

   always @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int l = 0; l < LANES; l++) cur_tap[l] <= '0;
      end else if (tap_ld) begin
         for (int l = 0; l < LANES; l++) cur_tap[l] <= tap_val[l*TAP_W +: TAP_W];
      end
   end

   always_comb begin
      dout_1 = PAT_1;
      dout_2 = PAT_2;
      for (int l = 0; l < LANES; l++) begin
         if (!pass_tbl[l][cur_tap[l]]) begin
            if (brk_mode[0]) dout_1[l] = ~PAT_1[l];
            if (brk_mode[1]) dout_2[l] = ~PAT_2[l];
         end
      end
      dout_1 = dout_1 ^ flip;
   end

   function automatic logic [31:0] win(input int a, input int b);
      logic [31:0] w = '0;
      for (int i = a; i <= b; i++) w[i] = 1'b1;
      return w;
   endfunction

   function automatic logic [31:0] rand_tbl();
      int m = $urandom_range(0, 5);
      int a = $urandom_range(0, 31);
      int b = $urandom_range(a, 31);
      int c = $urandom_range(0, 31);
      int d = $urandom_range(c, (c + 12 > 31) ? 31 : c + 12);
      case (m)
         0:       return '0;
         1:       return '1;
         2, 3:    return win(a, b);
         default: return win(a, b) | win(c, d);
      endcase
   endfunction

   // Widest contiguous passing run, earliest wins ties; centre if wide enough.
   task automatic compute_exp();
      for (int l = 0; l < LANES; l++) begin
         int bs = 0, bl = 0, len;
         for (int s = 0; s < 32; s++) begin
            if (exp_tbl[l][s] && ((s == 0) ? 1'b1 : !exp_tbl[l][s-1])) begin
               len = 0;
               while (s + len < 32 && exp_tbl[l][s+len]) len++;
               if (len > bl) begin bl = len; bs = s; end
            end
         end
         e_ok[l] = (bl >= 4);
         e_taps[l*TAP_W +: TAP_W] = (bl >= 4) ? TAP_W'(bs + bl / 2) : TAP_W'(16);
      end
   endtask

   task automatic set_tables();
      for (int l = 0; l < LANES; l++) exp_tbl[l] = pass_tbl[l];
      brk_mode = $urandom_range(1, 3);
   endtask

   // Start a run and watch it; cycle n is the interval after the n-th edge
   // following the start sample. flip_mask is applied for the cycle flip_at.
   task automatic do_run(input int flip_at, input logic [LANES-1:0] flip_mask,
                         input int restart_at);
      r_lat = -1; r_first_ld = -1; r_last_ld = -1;
      @(negedge dclk); start = 1'b1;
      @(posedge dclk);
      for (int n = 0; n < 3000; n++) begin
         @(negedge dclk);
         start = (n == restart_at);
         flip  = (n == flip_at) ? flip_mask : '0;
         if (n == 0) begin r_busy0 = busy; r_tm0 = test_mode; end
         if (tap_ld) begin
            if (r_first_ld < 0) r_first_ld = n;
            r_last_ld = n;
         end
         if (done) begin
            r_lat = n; r_busy_d = busy; r_tm_d = test_mode;
            r_taps = tap_val; r_ok = lane_ok; r_fail = fail;
            break;
         end
         @(posedge dclk);
      end
      start = 1'b0;
      flip  = '0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({test_mode, tap_val, tap_ld, busy, done, fail, lane_ok} !== '0) begin
         errors++;
         $display("FAIL reset_state: got tm=%b tap=%h ld=%b busy=%b done=%b fail=%b ok=%h, want all 0",
                  test_mode, tap_val, tap_ld, busy, done, fail, lane_ok);
      end
   endtask

   task automatic test_common_window();
      for (int l = 0; l < LANES; l++) pass_tbl[l] = win(10, 20);
      set_tables(); compute_exp();
      do_run(-1, '0, -1);
      vectors++; if (r_lat !== RUN) begin errors++; $display("FAIL common_latency: got %0d want %0d", r_lat, RUN); end
      vectors++; if (r_busy0 !== 1'b1 || r_tm0 !== 1'b1) begin errors++; $display("FAIL common_busy_rise: got busy=%b tm=%b want 1 1", r_busy0, r_tm0); end
      vectors++; if (r_first_ld !== 1) begin errors++; $display("FAIL common_first_ld: got %0d want 1", r_first_ld); end
      vectors++; if (r_last_ld !== RUN - 1) begin errors++; $display("FAIL common_last_ld: got %0d want %0d", r_last_ld, RUN - 1); end
      vectors++; if (r_busy_d !== 1'b0 || r_tm_d !== 1'b0) begin errors++; $display("FAIL common_busy_fall: got busy=%b tm=%b want 0 0", r_busy_d, r_tm_d); end
      vectors++; if (r_taps !== e_taps || r_taps !== {LANES{5'd15}}) begin errors++; $display("FAIL common_taps: got %h want %h", r_taps, e_taps); end
      vectors++; if (r_ok !== 8'hFF || r_fail !== 1'b0) begin errors++; $display("FAIL common_ok: got ok=%h fail=%b want ff 0", r_ok, r_fail); end
   endtask

   task automatic test_mixed_lanes(input logic narrow7);
      for (int l = 0; l < LANES; l++) pass_tbl[l] = rand_tbl();
      pass_tbl[3] = '1;
      pass_tbl[5] = win(2, 6) | win(20, 29);
      pass_tbl[6] = win(4, 9) | win(15, 20);
      pass_tbl[7] = narrow7 ? win(11, 13) : '0;
      set_tables(); compute_exp();
      do_run(-1, '0, -1);
      vectors++; if (r_lat !== RUN) begin errors++; $display("FAIL mixed_latency: got %0d want %0d", r_lat, RUN); end
      vectors++; if (r_taps !== e_taps) begin errors++; $display("FAIL mixed_taps: got %h want %h", r_taps, e_taps); end
      vectors++; if (r_ok !== e_ok || r_fail !== ~&e_ok) begin errors++; $display("FAIL mixed_ok: got ok=%h fail=%b want %h %b", r_ok, r_fail, e_ok, ~&e_ok); end
      vectors++; if (r_taps[3*5 +: 5] !== 5'd16 || r_taps[5*5 +: 5] !== 5'd25 || r_taps[6*5 +: 5] !== 5'd7 || r_taps[7*5 +: 5] !== 5'd16 || r_ok[7] !== 1'b0 || r_fail !== 1'b1) begin
         errors++; $display("FAIL mixed_fixed_lanes: got taps3/5/6/7=%0d/%0d/%0d/%0d ok7=%b fail=%b want 16/25/7/16 0 1",
                             r_taps[15 +: 5], r_taps[25 +: 5], r_taps[30 +: 5], r_taps[35 +: 5], r_ok[7], r_fail);
      end
   endtask

   // Lane 0 window 8..24; one-cycle flip either inside CHECK or in SETTLE of tap 12.
   task automatic test_glitch(input logic in_check);
      for (int l = 0; l < LANES; l++) pass_tbl[l] = rand_tbl();
      pass_tbl[0] = win(8, 24);
      set_tables();
      if (in_check) exp_tbl[0][12] = 1'b0;
      compute_exp();
      do_run(in_check ? 82*12 + 40 : 82*12 + 5, 8'h01, -1);
      vectors++; if (r_taps !== e_taps) begin errors++; $display("FAIL glitch_taps(chk=%b): got %h want %h", in_check, r_taps, e_taps); end
      vectors++; if (r_taps[4:0] !== (in_check ? 5'd19 : 5'd16)) begin errors++; $display("FAIL glitch_lane0(chk=%b): got %0d want %0d", in_check, r_taps[4:0], in_check ? 19 : 16); end
      vectors++; if (r_ok !== e_ok || r_fail !== ~&e_ok) begin errors++; $display("FAIL glitch_ok: got %h %b want %h %b", r_ok, r_fail, e_ok, ~&e_ok); end
   endtask

   task automatic test_start_while_busy();
      for (int l = 0; l < LANES; l++) pass_tbl[l] = rand_tbl();
      set_tables(); compute_exp();
      do_run(-1, '0, 500);
      vectors++; if (r_lat !== RUN) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", r_lat, RUN); end
      vectors++; if (r_taps !== e_taps || r_ok !== e_ok) begin errors++; $display("FAIL busy_start_result: got %h/%h want %h/%h", r_taps, r_ok, e_taps, e_ok); end
   endtask

   task automatic test_random(input int runs);
      for (int k = 0; k < runs; k++) begin
         for (int l = 0; l < LANES; l++) pass_tbl[l] = rand_tbl();
         set_tables(); compute_exp();
         do_run(-1, '0, -1);
         vectors++; if (r_lat !== RUN) begin errors++; $display("FAIL random%0d_latency: got %0d want %0d", k, r_lat, RUN); end
         vectors++; if (r_taps !== e_taps) begin errors++; $display("FAIL random%0d_taps: got %h want %h", k, r_taps, e_taps); end
         vectors++; if (r_ok !== e_ok || r_fail !== ~&e_ok) begin errors++; $display("FAIL random%0d_ok: got %h %b want %h %b", k, r_ok, r_fail, e_ok, ~&e_ok); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      for (int l = 0; l < LANES; l++) pass_tbl[l] = win(10, 20);
      set_tables();
      @(negedge dclk); start = 1'b1;
      @(posedge dclk);
      @(negedge dclk); start = 1'b0;
      repeat (82*20 + 30) @(posedge dclk);
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({test_mode, tap_val, tap_ld, busy, done, fail, lane_ok} !== '0) begin
         errors++;
         $display("FAIL midreset_async: got tm=%b tap=%h ld=%b busy=%b done=%b fail=%b ok=%h, want all 0",
                  test_mode, tap_val, tap_ld, busy, done, fail, lane_ok);
      end
      repeat (3) @(negedge dclk);
      reset_n = 1'b1;
      repeat (100) @(negedge dclk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || tap_ld !== 1'b0) begin
         errors++; $display("FAIL midreset_stays_idle: got busy=%b done=%b ld=%b want 0 0 0", busy, done, tap_ld);
      end
      test_random(1);
   endtask

   initial begin
      for (int l = 0; l < LANES; l++) pass_tbl[l] = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge dclk);
      test_reset();
      reset_n = 1'b1;
      @(negedge dclk);
      test_common_window();
      test_mixed_lanes(1'b0);
      test_mixed_lanes(1'b1);
      test_glitch(1'b1);
      test_glitch(1'b0);
      test_start_while_busy();
      test_random(3);
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
